// File: rtl/shift_agc_pkg.sv
// Shared types and helpers for the shift_agc runtime-scaling controller.
package shift_agc_pkg;

    // Controller states: IDLE freezes the shift, RUN gathers window statistics
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Largest value representable in a signed sample of the given width
    function automatic longint sat_max(input int width);
        return (longint'(1) <<< (width - 1)) - longint'(1);
    endfunction

    // Smallest value representable in a signed sample of the given width
    function automatic longint sat_min(input int width);
        return -(longint'(1) <<< (width - 1));
    endfunction

    // Headroom band: results inside this range could take one more left shift
    function automatic longint half_max(input int width);
        return sat_max(width - 1);
    endfunction

    function automatic longint half_min(input int width);
        return sat_min(width - 1);
    endfunction

    // Clamp a requested shift into the allowed range
    function automatic int clamp_shift(input int value, input int lo, input int hi);
        if (value < lo) begin
            return lo;
        end
        if (value > hi) begin
            return hi;
        end
        return value;
    endfunction

endpackage

// File: rtl/shift_agc_if.sv
// Sample stream, control and status bundle of the shift_agc block.
interface shift_agc_if #(
    parameter int DATA_WIDTH  = 16,
    parameter int SHIFT_WIDTH = 5
);
    logic signed [DATA_WIDTH-1:0]  din;
    logic                          din_valid;
    logic                          enable;
    logic                          shift_load;
    logic signed [SHIFT_WIDTH-1:0] shift_load_value;
    logic signed [DATA_WIDTH-1:0]  dout;
    logic                          dout_valid;
    logic [1:0]                    warning;
    logic signed [SHIFT_WIDTH-1:0] shift_out;
    logic                          shift_update;

    modport master (
        output din, din_valid, enable, shift_load, shift_load_value,
        input  dout, dout_valid, warning, shift_out, shift_update
    );

    modport slave (
        input  din, din_valid, enable, shift_load, shift_load_value,
        output dout, dout_valid, warning, shift_out, shift_update
    );
endinterface

// File: rtl/shift_agc_var_shift_sat.sv
// Registered variable arithmetic shift with saturation and overflow flags.
// The combinational sat_now/beyond_half flags describe the sample being
// captured on the coming edge so the controller can count it in the same cycle.
module var_shift_sat
    import shift_agc_pkg::*;
#(
    parameter int DATA_WIDTH  = 16,
    parameter int SHIFT_WIDTH = 5
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic signed [DATA_WIDTH-1:0]  din,
    input  logic                          din_valid,
    input  logic signed [SHIFT_WIDTH-1:0] shift,
    output logic                          sat_now,
    output logic                          beyond_half,
    output logic signed [DATA_WIDTH-1:0]  dout,
    output logic                          dout_valid,
    output logic [1:0]                    warning
);

    // Wide enough for the largest left shift the shift field can express
    localparam int EXT = DATA_WIDTH + 2 ** (SHIFT_WIDTH - 1) + 1;

    localparam logic signed [EXT-1:0] SAT_HI  = EXT'(sat_max(DATA_WIDTH));
    localparam logic signed [EXT-1:0] SAT_LO  = EXT'(sat_min(DATA_WIDTH));
    localparam logic signed [EXT-1:0] HALF_HI = EXT'(half_max(DATA_WIDTH));
    localparam logic signed [EXT-1:0] HALF_LO = EXT'(half_min(DATA_WIDTH));

    logic signed [EXT-1:0]        wide;
    logic signed [EXT-1:0]        shifted;
    logic [SHIFT_WIDTH-1:0]       shift_mag;
    logic                         pos_sat;
    logic                         neg_sat;
    logic signed [DATA_WIDTH-1:0] sat_val;

    // Full-precision shift, then clamp to the sample range and flag overflow
    always_comb begin
        wide      = EXT'(din);
        shift_mag = shift[SHIFT_WIDTH-1] ? $unsigned(-shift) : $unsigned(shift);
        if (shift[SHIFT_WIDTH-1]) begin
            shifted = wide >>> shift_mag;
        end else begin
            shifted = wide <<< shift_mag;
        end
        pos_sat     = shifted > SAT_HI;
        neg_sat     = shifted < SAT_LO;
        sat_now     = pos_sat || neg_sat;
        beyond_half = (shifted > HALF_HI) || (shifted < HALF_LO);
        if (pos_sat) begin
            sat_val = DATA_WIDTH'(SAT_HI);
        end else if (neg_sat) begin
            sat_val = DATA_WIDTH'(SAT_LO);
        end else begin
            sat_val = shifted[DATA_WIDTH-1:0];
        end
    end

    // One-cycle output register for the scaled sample and its flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout       <= '0;
            dout_valid <= 1'b0;
            warning    <= 2'b00;
        end else begin
            dout       <= sat_val;
            dout_valid <= din_valid;
            warning    <= {neg_sat, pos_sat};
        end
    end

endmodule

// File: rtl/shift_agc.sv
// Automatic gain control for the DSP shift path: gathers overflow and headroom
// statistics over fixed windows of valid samples and nudges the shift by one
// step per window; a software load overrides the shift at any time.
module shift_agc
    import shift_agc_pkg::*;
#(
    parameter int DATA_WIDTH  = 16,
    parameter int SHIFT_WIDTH = 5,
    parameter int SHIFT_MIN   = -7,
    parameter int SHIFT_MAX   = 7,
    parameter int INIT_SHIFT  = 0,
    parameter int WINDOW_LOG2 = 10,
    parameter int OVF_THRESH  = 4
) (
    input logic       clk,
    input logic       rst,
    shift_agc_if.slave bus
);

    localparam int OCW = (OVF_THRESH < 1) ? 1 : $clog2(OVF_THRESH + 1);

    localparam logic [OCW-1:0]                OVF_LIMIT  = OCW'(OVF_THRESH);
    localparam logic signed [SHIFT_WIDTH-1:0] SHIFT_LO   = SHIFT_WIDTH'(SHIFT_MIN);
    localparam logic signed [SHIFT_WIDTH-1:0] SHIFT_HI   = SHIFT_WIDTH'(SHIFT_MAX);
    localparam logic signed [SHIFT_WIDTH-1:0] SHIFT_INIT = SHIFT_WIDTH'(INIT_SHIFT);
    localparam logic signed [SHIFT_WIDTH-1:0] ONE        = SHIFT_WIDTH'(1);

    state_t                        state;
    state_t                        next_state;
    logic signed [SHIFT_WIDTH-1:0] shift_reg;
    logic                          shift_update_q;
    logic [WINDOW_LOG2-1:0]        win_cnt;
    logic [OCW-1:0]                ovf_cnt;
    logic                          headroom;

    logic                          sat_now;
    logic                          beyond_half;
    logic                          active;
    logic                          sample;
    logic                          win_last;
    logic [OCW-1:0]                ovf_next;
    logic                          head_next;
    logic                          do_dec;
    logic                          do_inc;
    logic signed [SHIFT_WIDTH-1:0] load_clamped;

    var_shift_sat #(
        .DATA_WIDTH (DATA_WIDTH),
        .SHIFT_WIDTH(SHIFT_WIDTH)
    ) u_shift (
        .clk        (clk),
        .rst        (rst),
        .din        (bus.din),
        .din_valid  (bus.din_valid),
        .shift      (shift_reg),
        .sat_now    (sat_now),
        .beyond_half(beyond_half),
        .dout       (bus.dout),
        .dout_valid (bus.dout_valid),
        .warning    (bus.warning)
    );

    assign bus.shift_out    = shift_reg;
    assign bus.shift_update = shift_update_q;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next state follows enable; leaving RUN drops the partial window
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (bus.enable)  next_state = RUN;
            RUN:     if (!bus.enable) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Window statistics including the sample on this edge, and the decision
    always_comb begin
        active   = (state == RUN) && bus.enable;
        sample   = active && bus.din_valid;
        win_last = sample && (win_cnt == '1);
        ovf_next = ovf_cnt;
        if (sample && sat_now && (ovf_cnt != '1)) begin
            ovf_next = ovf_cnt + 1'b1;
        end
        head_next    = headroom && !(sample && beyond_half);
        do_dec       = win_last && (ovf_next >= OVF_LIMIT) && (shift_reg > SHIFT_LO);
        do_inc       = win_last && !do_dec && head_next && (shift_reg < SHIFT_HI);
        load_clamped = SHIFT_WIDTH'(clamp_shift(int'(bus.shift_load_value), SHIFT_MIN, SHIFT_MAX));
    end

    // Shift register, update pulse and window counters; a load beats the decision
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_reg      <= SHIFT_INIT;
            shift_update_q <= 1'b0;
            win_cnt        <= '0;
            ovf_cnt        <= '0;
            headroom       <= 1'b1;
        end else begin
            shift_update_q <= 1'b0;
            if (bus.shift_load) begin
                shift_reg <= load_clamped;
                win_cnt   <= '0;
                ovf_cnt   <= '0;
                headroom  <= 1'b1;
            end else if (!active) begin
                win_cnt  <= '0;
                ovf_cnt  <= '0;
                headroom <= 1'b1;
            end else if (win_last) begin
                win_cnt  <= '0;
                ovf_cnt  <= '0;
                headroom <= 1'b1;
                if (do_dec) begin
                    shift_reg      <= shift_reg - ONE;
                    shift_update_q <= 1'b1;
                end else if (do_inc) begin
                    shift_reg      <= shift_reg + ONE;
                    shift_update_q <= 1'b1;
                end
            end else if (sample) begin
                win_cnt  <= win_cnt + 1'b1;
                ovf_cnt  <= ovf_next;
                headroom <= head_next;
            end
        end
    end

endmodule

// File: tb/tb_shift_agc.sv
// Directed bench for shift_agc: datapath vectors from a table, then
// hand-built window sequences for the automatic controller.
module tb_shift_agc;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    shift_agc_if #(.DATA_WIDTH(16), .SHIFT_WIDTH(5)) bus ();

    shift_agc #(
        .DATA_WIDTH (16),
        .SHIFT_WIDTH(5),
        .SHIFT_MIN  (-7),
        .SHIFT_MAX  (7),
        .INIT_SHIFT (0),
        .WINDOW_LOG2(4),
        .OVF_THRESH (2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        logic [15:0] din;
        logic        valid;
        logic        load;
        logic [4:0]  load_val;
        logic        exp_valid;
        logic [15:0] exp_dout;
        logic [1:0]  exp_warn;
        logic [4:0]  exp_shift;
    } vec_t;

    vec_t vecs[22];

    // Free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    // Drive one cycle of inputs, clock it in, and settle just after the edge
    task automatic applyStimulus(input logic [15:0] d, input logic v, input logic ld, input logic [4:0] lv);
        bus.din              = d;
        bus.din_valid        = v;
        bus.shift_load       = ld;
        bus.shift_load_value = lv;
        @(posedge clk);
        #1;
        bus.din_valid  = 1'b0;
        bus.shift_load = 1'b0;
    endtask

    // Stream n identical samples; the pulse is expected only on the last one
    task automatic feedWindow(input string name, input logic [15:0] d, input int n,
                              input bit pulse_last, input logic [4:0] exp_shift);
        for (int i = 0; i < n; i++) begin
            applyStimulus(d, 1'b1, 1'b0, 5'd0);
            checkOutput($sformatf("%s upd%0d", name, i), {31'b0, bus.shift_update},
                        {31'b0, (pulse_last && (i == n - 1))});
        end
        checkOutput({name, " shift"}, {27'b0, bus.shift_out}, {27'b0, exp_shift});
    endtask

    initial begin
        total                = 0;
        bad                  = 0;
        rst                  = 1'b1;
        bus.din              = '0;
        bus.din_valid        = 1'b0;
        bus.enable           = 1'b0;
        bus.shift_load       = 1'b0;
        bus.shift_load_value = '0;

        //            din      v     ld    lval    ev    dout     warn   shift
        vecs[0]  = '{16'h1234, 1'b1, 1'b0, 5'h00, 1'b1, 16'h1234, 2'b00, 5'h00};
        vecs[1]  = '{16'h0000, 1'b0, 1'b1, 5'h02, 1'b0, 16'h0000, 2'b00, 5'h02};
        vecs[2]  = '{16'h3000, 1'b1, 1'b0, 5'h00, 1'b1, 16'h7FFF, 2'b01, 5'h02};
        vecs[3]  = '{16'hD000, 1'b1, 1'b0, 5'h00, 1'b1, 16'h8000, 2'b10, 5'h02};
        vecs[4]  = '{16'h0000, 1'b0, 1'b1, 5'h1D, 1'b0, 16'h0000, 2'b00, 5'h1D};
        vecs[5]  = '{16'hFFFB, 1'b1, 1'b0, 5'h00, 1'b1, 16'hFFFF, 2'b00, 5'h1D};
        vecs[6]  = '{16'h7FFF, 1'b1, 1'b0, 5'h00, 1'b1, 16'h0FFF, 2'b00, 5'h1D};
        vecs[7]  = '{16'h0000, 1'b0, 1'b1, 5'h0C, 1'b0, 16'h0000, 2'b00, 5'h07};
        vecs[8]  = '{16'h0000, 1'b0, 1'b1, 5'h10, 1'b0, 16'h0000, 2'b00, 5'h19};
        vecs[9]  = '{16'h8000, 1'b1, 1'b0, 5'h00, 1'b1, 16'hFF00, 2'b00, 5'h19};
        vecs[10] = '{16'h0000, 1'b0, 1'b1, 5'h01, 1'b0, 16'h0000, 2'b00, 5'h01};
        vecs[11] = '{16'h4000, 1'b1, 1'b0, 5'h00, 1'b1, 16'h7FFF, 2'b01, 5'h01};
        vecs[12] = '{16'hC000, 1'b1, 1'b0, 5'h00, 1'b1, 16'h8000, 2'b00, 5'h01};
        vecs[13] = '{16'h3FFF, 1'b1, 1'b0, 5'h00, 1'b1, 16'h7FFE, 2'b00, 5'h01};
        vecs[14] = '{16'h0100, 1'b1, 1'b1, 5'h00, 1'b1, 16'h0200, 2'b00, 5'h00};
        vecs[15] = '{16'h8000, 1'b1, 1'b0, 5'h00, 1'b1, 16'h8000, 2'b00, 5'h00};
        vecs[16] = '{16'h7FFF, 1'b1, 1'b0, 5'h00, 1'b1, 16'h7FFF, 2'b00, 5'h00};
        vecs[17] = '{16'h0000, 1'b0, 1'b1, 5'h07, 1'b0, 16'h0000, 2'b00, 5'h07};
        vecs[18] = '{16'h00FF, 1'b1, 1'b0, 5'h00, 1'b1, 16'h7F80, 2'b00, 5'h07};
        vecs[19] = '{16'hFF00, 1'b1, 1'b0, 5'h00, 1'b1, 16'h8000, 2'b00, 5'h07};
        vecs[20] = '{16'hFEFF, 1'b1, 1'b0, 5'h00, 1'b1, 16'h8000, 2'b10, 5'h07};
        vecs[21] = '{16'h0000, 1'b0, 1'b1, 5'h00, 1'b0, 16'h0000, 2'b00, 5'h00};

        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst dout", {16'b0, bus.dout}, 32'h0);
        checkOutput("rst dout_valid", {31'b0, bus.dout_valid}, 32'h0);
        checkOutput("rst warning", {30'b0, bus.warning}, 32'h0);
        checkOutput("rst shift_out", {27'b0, bus.shift_out}, 32'h0);
        checkOutput("rst shift_update", {31'b0, bus.shift_update}, 32'h0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        $display("[TB] datapath vectors, controller idle");
        for (int i = 0; i < 22; i++) begin
            applyStimulus(vecs[i].din, vecs[i].valid, vecs[i].load, vecs[i].load_val);
            checkOutput($sformatf("vec%0d dout_valid", i), {31'b0, bus.dout_valid}, {31'b0, vecs[i].exp_valid});
            if (vecs[i].exp_valid) begin
                checkOutput($sformatf("vec%0d dout", i), {16'b0, bus.dout}, {16'b0, vecs[i].exp_dout});
                checkOutput($sformatf("vec%0d warning", i), {30'b0, bus.warning}, {30'b0, vecs[i].exp_warn});
            end
            checkOutput($sformatf("vec%0d shift_out", i), {27'b0, bus.shift_out}, {27'b0, vecs[i].exp_shift});
            checkOutput($sformatf("vec%0d shift_update", i), {31'b0, bus.shift_update}, 32'h0);
        end

        $display("[TB] headroom window raises shift");
        bus.enable = 1'b1;
        applyStimulus(16'h0000, 1'b0, 1'b0, 5'h00);
        feedWindow("inc", 16'h0100, 16, 1'b1, 5'h01);
        applyStimulus(16'h0100, 1'b1, 1'b0, 5'h00);
        checkOutput("inc next dout", {16'b0, bus.dout}, 32'h0200);
        checkOutput("inc next update", {31'b0, bus.shift_update}, 32'h0);

        $display("[TB] overflow window lowers shift");
        applyStimulus(16'h0000, 1'b0, 1'b1, 5'h01);
        checkOutput("dec load shift", {27'b0, bus.shift_out}, 32'h1);
        for (int i = 0; i < 16; i++) begin
            applyStimulus((i == 2 || i == 5 || i == 9) ? 16'h5000 : 16'h0010, 1'b1, 1'b0, 5'h00);
            checkOutput($sformatf("dec upd%0d", i), {31'b0, bus.shift_update}, {31'b0, (i == 15)});
            if (i == 2) begin
                checkOutput("dec sat dout", {16'b0, bus.dout}, 32'h7FFF);
                checkOutput("dec sat warning", {30'b0, bus.warning}, 32'h1);
            end
        end
        checkOutput("dec shift", {27'b0, bus.shift_out}, 32'h0);

        $display("[TB] no headroom and no overflow holds shift");
        feedWindow("hold", 16'h5000, 16, 1'b0, 5'h00);

        $display("[TB] load on window end, then enable drop");
        feedWindow("ldwin", 16'h0100, 15, 1'b0, 5'h00);
        applyStimulus(16'h0100, 1'b1, 1'b1, 5'h03);
        checkOutput("ldwin shift", {27'b0, bus.shift_out}, 32'h3);
        checkOutput("ldwin update", {31'b0, bus.shift_update}, 32'h0);
        feedWindow("part", 16'h0001, 8, 1'b0, 5'h03);
        bus.enable = 1'b0;
        applyStimulus(16'h0000, 1'b0, 1'b0, 5'h00);
        bus.enable = 1'b1;
        applyStimulus(16'h0000, 1'b0, 1'b0, 5'h00);
        feedWindow("fresh", 16'h0001, 15, 1'b0, 5'h03);
        feedWindow("fresh end", 16'h0001, 1, 1'b1, 5'h04);

        $display("[TB] shift range limits");
        applyStimulus(16'h0000, 1'b0, 1'b1, 5'h07);
        checkOutput("max load", {27'b0, bus.shift_out}, 32'h7);
        feedWindow("at max", 16'h0001, 16, 1'b0, 5'h07);
        applyStimulus(16'h0000, 1'b0, 1'b1, 5'h19);
        checkOutput("min load", {27'b0, bus.shift_out}, 32'h19);
        feedWindow("at min", 16'h0001, 16, 1'b1, 5'h1A);
        applyStimulus(16'h0000, 1'b0, 1'b1, 5'h0C);
        checkOutput("clamp load", {27'b0, bus.shift_out}, 32'h7);
        checkOutput("clamp update", {31'b0, bus.shift_update}, 32'h0);

        $display("[TB] frozen while disabled");
        bus.enable = 1'b0;
        applyStimulus(16'h0000, 1'b0, 1'b1, 5'h00);
        feedWindow("frozen", 16'h0001, 16, 1'b0, 5'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/shift_agc.md
# shift_agc

Runtime-scaling controller for the DSP shift path: applies a variable, saturating arithmetic shift to a signed sample stream and picks the shift amount itself from overflow and headroom statistics collected over fixed sample windows. It sits between a fixed-point producer (FFT, accumulator, filter) and downstream fixed-width consumers. It replaces compile-time shift selection where signal level is not known at build time. Software can override the shift at any time.

## Interface
- DATA_WIDTH, 16, sample width (signed two's complement)
- SHIFT_WIDTH, 5, width of signed shift amount
- SHIFT_MIN, -7, lowest shift allowed (negative = right shift)
- SHIFT_MAX, 7, highest shift allowed (positive = left shift)
- INIT_SHIFT, 0, shift after reset
- WINDOW_LOG2, 10, window length = 2**WINDOW_LOG2 valid samples
- OVF_THRESH, 4, saturated samples per window that force a decrement
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- din  in  DATA_WIDTH  signed input sample
- din_valid  in  1  sample qualifier
- enable  in  1  1 = automatic adjustment on, 0 = shift frozen
- shift_load  in  1  one-cycle strobe that loads shift_load_value
- shift_load_value  in  SHIFT_WIDTH  signed shift to load, clamped to [SHIFT_MIN, SHIFT_MAX]
- dout  out  DATA_WIDTH  scaled, saturated sample
- dout_valid  out  1  dout qualifier
- warning  out  2  [0] positive saturation, [1] negative saturation on this dout
- shift_out  out  SHIFT_WIDTH  shift currently applied
- shift_update  out  1  one-cycle pulse when the auto controller changes shift_out

## Operation
- Datapath:
  - Intermediate r = din·2**shift, computed at full precision.
  - Negative shift is an arithmetic right shift (floor), so -5 >>> 3 = -1.
  - dout = r clamped to [-2**(DATA_WIDTH-1), 2**(DATA_WIDTH-1)-1].
  - warning[0] = (r > max); warning[1] = (r < min).
- Per valid sample, while in RUN:
  - win_cnt increments.
  - ovf_cnt increments (saturating) if warning is nonzero.
  - The headroom flag clears if r is outside [-2**(DATA_WIDTH-2), 2**(DATA_WIDTH-2)-1].
- FSM states:
  - IDLE (enable=0): shift frozen; win_cnt, ovf_cnt and headroom are held at their cleared values (0, 0, 1); the datapath still runs.
  - RUN (enable=1): accumulate statistics.
  - IDLE→RUN when enable=1. RUN→IDLE when enable=0, which discards the partial window.
- Window end = valid sample that wraps win_cnt to 0. Decision, evaluated with that sample included:
  - if ovf_cnt ≥ OVF_THRESH and shift > SHIFT_MIN → shift−1;
  - else if headroom and shift < SHIFT_MAX → shift+1;
  - else hold, and shift_update stays 0.
- At window end, the counters and headroom flag reset for the next window.
- shift_load:
  - Sets the shift (clamped) and clears the window statistics, in any state.
  - Has priority over a simultaneous window-end decision; shift_update stays 0 in that case.
- Reset values:
  - dout=0, dout_valid=0, warning=0, shift_update=0.
  - shift_out=INIT_SHIFT; counters 0; headroom=1; state IDLE.

## Timing
- Datapath latency is 1 cycle: din/din_valid at edge N appear as dout/dout_valid/warning after edge N. dout_valid is din_valid delayed by one cycle.
- No backpressure; a valid sample is accepted every cycle.
- A shift change (auto or load) registers on edge N. The sample captured at edge N uses the old shift; the sample at edge N+1 uses the new one.
- shift_update is high for the single cycle following the edge where the shift changes.
- Asserting rst mid-window aborts it immediately. No output glitches beyond the reset values.

## Structure
- Shared package shift_agc_pkg holds:
  - the FSM state enum (IDLE, RUN);
  - saturation-limit constants derived from DATA_WIDTH;
  - the clamp function for shift values.
- Sub-module var_shift_sat: registered variable arithmetic shift with saturation and the warning bits.
- shift_agc holds the FSM, counters, decision logic and load path.

## Test plan
All scenarios use DATA_WIDTH=16, WINDOW_LOG2=4 (16-sample window), OVF_THRESH=2.
- Reset, then din=0x1234 valid with shift 0 → one cycle later dout=0x1234, warning=00, shift_out=0.
- Load shift 2; din=0x3000 → dout=0x7FFF, warning=01. din=0xD000 → dout=0x8000, warning=10. Load −3, din=−5 → dout=−1.
- enable=1, shift 0, 16 samples of 0x0100 → shift_update pulses once and shift_out=1; the 17th sample 0x0100 → dout=0x0200.
- Load shift 1; 16 samples with three at 0x5000, rest 0x0010 → ovf_cnt=3, shift_out=0 after the 16th, shift_update pulses.
- shift_load asserted on the window-end sample, with a value of 3 → shift_out=3, no shift_update, next window counted from zero. enable dropped after 8 samples then re-raised → no update until 16 fresh samples.
- Load shift 7, 16 samples of 0x0001 → shift_out stays 7, no pulse. Load shift −7, 16 saturating-free samples → no decrement; clamped load of 12 → shift_out=7.
